wb_writer: RTL and testbench
============================

// Module: wb_writer
// PURPOSE
//  Write-back stage driver: sole producer of the register file write port (destWB/resultWB/writeBackEn).
//  Accepts retiring instructions from the MEM stage via valid/ready.
//  Returns ALU results with 1-cycle latency; holds the pipeline while a multi-cycle data-memory load is outstanding.
//  Exports the pending load destination to the hazard unit; flags load timeouts and stray responses.
// PARAMETERS
//  DATA_W        32  width of results and load data
//  REG_AW        4   register index width (16 architectural regs)
//  LOAD_TIMEOUT  16  max cycles spent in LOAD_WAIT before the load is abandoned (>=1)
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       asynchronous reset, active-high
//  memValid      in   1       MEM stage presents a retiring instruction
//  memReady      out  1       wb_writer accepts it (transfer = memValid & memReady)
//  memWbEn       in   1       instruction writes a register
//  memRdEn       in   1       instruction is a load (result comes from ldRespData)
//  memDest       in   REG_AW  destination register index
//  aluResult     in   DATA_W  ALU result for non-load instructions
//  ldRespValid   in   1       data memory returns load data this cycle
//  ldRespData    in   DATA_W  load data
//  destWB        out  REG_AW  register file write index
//  resultWB      out  DATA_W  register file write data
//  writeBackEn   out  1       register file write strobe, one-cycle pulse per write
//  pendingValid  out  1       a load is outstanding (hazard unit must stall readers of pendingDest)
//  pendingDest   out  REG_AW  destination of the outstanding load
//  loadErr       out  1       sticky error: timeout or stray load response
//  retiredCount  out  32      number of writeBackEn pulses, wraps modulo 2^32
// BEHAVIOUR
//  Reset: state IDLE.
//   destWB, resultWB, pendingDest = 0.
//   writeBackEn, pendingValid, loadErr = 0.
//   retiredCount = 0; timeout counter = 0.
//  Outputs: all registered. memReady is combinational from state: 1 in IDLE, 0 in LOAD_WAIT.
//  IDLE, on transfer:
//   - memWbEn=1, memRdEn=0: next cycle writeBackEn=1, destWB=memDest, resultWB=aluResult.
//   - memWbEn=1, memRdEn=1: capture memDest into pendingDest; pendingValid=1 next cycle; go LOAD_WAIT.
//     No write this cycle; timeout counter cleared to 0.
//   - memWbEn=0: no write; memRdEn ignored; stays IDLE.
//  IDLE, no transfer: writeBackEn=0 next cycle.
//  Throughput: back-to-back ALU transfers give back-to-back writeBackEn pulses, one per cycle.
//  LOAD_WAIT:
//   - ldRespValid=1: next cycle writeBackEn=1, destWB=pendingDest, resultWB=ldRespData,
//     pendingValid=0; go IDLE.
//   - else if timeout counter == LOAD_TIMEOUT-1: next cycle loadErr=1, pendingValid=0, no write; go IDLE.
//   - else: counter increments.
//   - A response on the last allowed cycle wins over timeout.
//  Stray response: ldRespValid=1 while in IDLE sets loadErr=1 and is otherwise ignored.
//   This includes a late response after a timeout.
//  An ALU transfer accepted in the same IDLE cycle as a stray response is still written normally.
//  Hold behaviour: destWB/resultWB hold their last value when writeBackEn=0.
//  loadErr clears only on rst.
//  retiredCount increments in the cycle writeBackEn is driven to 1.
//  R15 is written like any other register; no special handling.
//  Reset mid-load (rst in LOAD_WAIT) returns to IDLE with no write; a response arriving after reset counts as stray.
//  The register file samples the write on the negedge inside the writeBackEn=1 cycle, so a same-cycle read sees new data.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately, memReady=1.
//  2 ALU stream: 3 transfers dest=1,2,3 data=0x11,0x22,0x33 on consecutive cycles
//    -> writeBackEn high 3 consecutive cycles with matching dest/data; retiredCount=3.
//  3 Load: transfer dest=5 memRdEn=1; ldRespValid with 0xDEADBEEF 4 cycles later
//    -> memReady=0 and pendingValid=1, pendingDest=5 for 4 cycles;
//    -> then one pulse dest=5 data=0xDEADBEEF.
//  4 Timeout: load dest=7, no response -> after LOAD_TIMEOUT cycles: loadErr=1, no write, memReady=1;
//    response 2 cycles later is ignored and loadErr stays 1.
//  5 Edge: response exactly on cycle LOAD_TIMEOUT-1 of LOAD_WAIT -> write occurs, loadErr stays 0.
//  6 memWbEn=0 transfers (store/branch) -> no writeBackEn, retiredCount unchanged.
//    rst during LOAD_WAIT -> IDLE, no write.

Source files
------------

// File: rtl/wb_writer_if.sv
// Write-back bus bundle: MEM-stage retire handshake, data-memory load response,
// register file write port and the hazard-unit / status outputs of wb_writer.
//
// Handshake: an instruction transfers on a clock edge where memValid & memReady
// are both 1. The MEM side holds its payload stable while memValid=1 and
// memReady=0; memReady depends only on wb_writer state, never on memValid.
interface wb_writer_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              memValid;
   logic              memReady;
   logic              memWbEn;
   logic              memRdEn;
   logic [REG_AW-1:0] memDest;
   logic [DATA_W-1:0] aluResult;
   logic              ldRespValid;
   logic [DATA_W-1:0] ldRespData;
   logic [REG_AW-1:0] destWB;
   logic [DATA_W-1:0] resultWB;
   logic              writeBackEn;
   logic              pendingValid;
   logic [REG_AW-1:0] pendingDest;
   logic              loadErr;
   logic [31:0]       retiredCount;

   // Environment side: MEM stage, data memory, register file, hazard unit
   modport master (
      output memValid, memWbEn, memRdEn, memDest, aluResult,
      output ldRespValid, ldRespData,
      input  memReady, destWB, resultWB, writeBackEn,
      input  pendingValid, pendingDest, loadErr, retiredCount
   );

   // wb_writer side
   modport slave (
      input  memValid, memWbEn, memRdEn, memDest, aluResult,
      input  ldRespValid, ldRespData,
      output memReady, destWB, resultWB, writeBackEn,
      output pendingValid, pendingDest, loadErr, retiredCount
   );
endinterface

// File: rtl/wb_writer.sv
// Write-back stage driver. Sole producer of the register file write port.
// ALU results are written one cycle after acceptance; a load parks the stage
// in LOAD_WAIT until the data memory answers or the timeout expires.
// All outputs except memReady are registered; memReady is decoded from state.
module wb_writer #(
   parameter int DATA_W       = 32,
   parameter int REG_AW       = 4,
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   wb_writer_if.slave        bus,
   output logic              o_dbg_state   // 0 = IDLE, 1 = LOAD_WAIT
);

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   // Counter only has to reach LOAD_TIMEOUT-1
   localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_timeout_cnt;
   logic [REG_AW-1:0] r_dest_wb;
   logic [DATA_W-1:0] r_result_wb;
   logic              r_wb_en;
   logic              r_pending_valid;
   logic [REG_AW-1:0] r_pending_dest;
   logic              r_load_err;
   logic [31:0]       r_retired_count;

   logic              w_transfer;

   assign w_transfer = bus.memValid & bus.memReady;

   // Stage FSM with all registered outputs; writeBackEn defaults low so it
   // is a single-cycle pulse per write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_timeout_cnt   <= '0;
         r_dest_wb       <= '0;
         r_result_wb     <= '0;
         r_wb_en         <= 1'b0;
         r_pending_valid <= 1'b0;
         r_pending_dest  <= '0;
         r_load_err      <= 1'b0;
         r_retired_count <= '0;
      end else begin
         r_wb_en <= 1'b0;
         case (r_state)
            IDLE: begin
               // Any response with no load outstanding is stray (includes
               // a late answer after a timeout); it never writes
               if (bus.ldRespValid) begin
                  r_load_err <= 1'b1;
               end
               if (w_transfer && bus.memWbEn) begin
                  if (bus.memRdEn) begin
                     r_pending_dest  <= bus.memDest;
                     r_pending_valid <= 1'b1;
                     r_timeout_cnt   <= '0;
                     r_state         <= LOAD_WAIT;
                  end else begin
                     r_wb_en         <= 1'b1;
                     r_dest_wb       <= bus.memDest;
                     r_result_wb     <= bus.aluResult;
                     r_retired_count <= r_retired_count + 32'd1;
                  end
               end
            end
            LOAD_WAIT: begin
               // Response is tested first so it wins on the last allowed cycle
               if (bus.ldRespValid) begin
                  r_wb_en         <= 1'b1;
                  r_dest_wb       <= r_pending_dest;
                  r_result_wb     <= bus.ldRespData;
                  r_retired_count <= r_retired_count + 32'd1;
                  r_pending_valid <= 1'b0;
                  r_state         <= IDLE;
               end else if (r_timeout_cnt == TO_LAST) begin
                  r_load_err      <= 1'b1;
                  r_pending_valid <= 1'b0;
                  r_state         <= IDLE;
               end else begin
                  r_timeout_cnt <= r_timeout_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Output mapping; memReady is decoded directly from state
   assign bus.memReady     = (r_state == IDLE);
   assign bus.destWB       = r_dest_wb;
   assign bus.resultWB     = r_result_wb;
   assign bus.writeBackEn  = r_wb_en;
   assign bus.pendingValid = r_pending_valid;
   assign bus.pendingDest  = r_pending_dest;
   assign bus.loadErr      = r_load_err;
   assign bus.retiredCount = r_retired_count;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: ALU stream, load with latency, timeout,
// last-cycle response, reset mid-load, stray responses, non-writing transfers.
module tb_wb_writer;
   localparam int DATA_W       = 32;
   localparam int REG_AW       = 4;
   localparam int LOAD_TIMEOUT = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dbg_state;
   always #5 clk = ~clk;

   wb_writer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

   wb_writer #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .LOAD_TIMEOUT(LOAD_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
   );

   int n_total = 0;
   int n_bad   = 0;

   // expected writes as {dest, data}
   logic [REG_AW+DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard on register file writes ----------------
   always @(negedge clk) begin
      if (!rst && bus.writeBackEn === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(bus.writeBackEn), 64'd0);
         end else begin
            check("write_data", 64'({bus.destWB, bus.resultWB}), 64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.memValid    = 1'b0;
      bus.memWbEn     = 1'b0;
      bus.memRdEn     = 1'b0;
      bus.memDest     = '0;
      bus.aluResult   = '0;
      bus.ldRespValid = 1'b0;
      bus.ldRespData  = '0;
   endtask

   task automatic alu(input logic [REG_AW-1:0] dest, input logic [DATA_W-1:0] data);
      bus.memValid  = 1'b1;
      bus.memWbEn   = 1'b1;
      bus.memRdEn   = 1'b0;
      bus.memDest   = dest;
      bus.aluResult = data;
      exp_q.push_back({dest, data});
      step();
      check("alu_wben", 64'(bus.writeBackEn), 64'd1);
   endtask

   task automatic start_load(input logic [REG_AW-1:0] dest);
      bus.memValid  = 1'b1;
      bus.memWbEn   = 1'b1;
      bus.memRdEn   = 1'b1;
      bus.memDest   = dest;
      bus.aluResult = 32'h0BAD_0BAD;
      step();
      drive_idle();
   endtask

   task automatic reset_mid_cycle();
      #2 rst = 1'b1;
      #1;
      check("rst_destWB", 64'(bus.destWB), 64'd0);
      check("rst_resultWB", 64'(bus.resultWB), 64'd0);
      check("rst_wben", 64'(bus.writeBackEn), 64'd0);
      check("rst_pendValid", 64'(bus.pendingValid), 64'd0);
      check("rst_pendDest", 64'(bus.pendingDest), 64'd0);
      check("rst_loadErr", 64'(bus.loadErr), 64'd0);
      check("rst_retired", 64'(bus.retiredCount), 64'd0);
      check("rst_memReady", 64'(bus.memReady), 64'd1);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      drive_idle();
      step();
      step();
      check("por_wben", 64'(bus.writeBackEn), 64'd0);
      check("por_retired", 64'(bus.retiredCount), 64'd0);
      check("por_memReady", 64'(bus.memReady), 64'd1);
      rst = 1'b0;
      step();

      // ALU stream: three back-to-back writes
      alu(4'd1, 32'h11);
      alu(4'd2, 32'h22);
      alu(4'd3, 32'h33);
      drive_idle();
      step();
      check("stream_end_wben", 64'(bus.writeBackEn), 64'd0);
      check("stream_retired", 64'(bus.retiredCount), 64'd3);
      check("hold_dest", 64'(bus.destWB), 64'd3);
      check("hold_data", 64'(bus.resultWB), 64'h33);

      // Load with response on the 4th LOAD_WAIT cycle
      start_load(4'd5);
      for (int i = 0; i < 4; i++) begin
         check("ld_memReady", 64'(bus.memReady), 64'd0);
         check("ld_pendValid", 64'(bus.pendingValid), 64'd1);
         check("ld_pendDest", 64'(bus.pendingDest), 64'd5);
         check("ld_nowrite", 64'(bus.writeBackEn), 64'd0);
         if (i == 3) begin
            bus.ldRespValid = 1'b1;
            bus.ldRespData  = 32'hDEAD_BEEF;
            exp_q.push_back({4'd5, 32'hDEAD_BEEF});
         end
         step();
      end
      drive_idle();
      check("ld_wben", 64'(bus.writeBackEn), 64'd1);
      check("ld_pend_clr", 64'(bus.pendingValid), 64'd0);
      check("ld_memReady_back", 64'(bus.memReady), 64'd1);
      check("ld_retired", 64'(bus.retiredCount), 64'd4);

      // Timeout: no response for LOAD_TIMEOUT cycles
      start_load(4'd7);
      for (int i = 0; i < LOAD_TIMEOUT; i++) begin
         check("to_pendValid", 64'(bus.pendingValid), 64'd1);
         check("to_loadErr_early", 64'(bus.loadErr), 64'd0);
         step();
      end
      check("to_loadErr", 64'(bus.loadErr), 64'd1);
      check("to_nowrite", 64'(bus.writeBackEn), 64'd0);
      check("to_memReady", 64'(bus.memReady), 64'd1);
      check("to_pend_clr", 64'(bus.pendingValid), 64'd0);
      step();
      bus.ldRespValid = 1'b1;              // late response, 2 cycles later
      bus.ldRespData  = 32'h1234_5678;
      step();
      drive_idle();
      check("late_nowrite", 64'(bus.writeBackEn), 64'd0);
      check("late_loadErr", 64'(bus.loadErr), 64'd1);
      check("late_retired", 64'(bus.retiredCount), 64'd4);

      // Reset in the middle of a load: back to IDLE, no write
      start_load(4'd9);
      step();
      check("rl_state", 64'(dbg_state), 64'd1);
      reset_mid_cycle();
      step();
      check("rl_nowrite", 64'(bus.writeBackEn), 64'd0);
      bus.ldRespValid = 1'b1;              // response now counts as stray
      bus.ldRespData  = 32'hAAAA_5555;
      step();
      drive_idle();
      check("rl_stray_err", 64'(bus.loadErr), 64'd1);
      check("rl_stray_nowrite", 64'(bus.writeBackEn), 64'd0);
      reset_mid_cycle();

      // Response on the last allowed LOAD_WAIT cycle wins over timeout
      start_load(4'd4);
      for (int i = 0; i < LOAD_TIMEOUT; i++) begin
         check("edge_pendValid", 64'(bus.pendingValid), 64'd1);
         if (i == LOAD_TIMEOUT - 1) begin
            bus.ldRespValid = 1'b1;
            bus.ldRespData  = 32'hCAFE_0005;
            exp_q.push_back({4'd4, 32'hCAFE_0005});
         end
         step();
      end
      drive_idle();
      check("edge_wben", 64'(bus.writeBackEn), 64'd1);
      check("edge_loadErr", 64'(bus.loadErr), 64'd0);
      check("edge_memReady", 64'(bus.memReady), 64'd1);
      check("edge_retired", 64'(bus.retiredCount), 64'd1);

      // Non-writing transfers; memRdEn is ignored when memWbEn=0
      bus.memValid = 1'b1;
      bus.memWbEn  = 1'b0;
      bus.memRdEn  = 1'b1;
      bus.memDest  = 4'd6;
      step();
      check("nw1_wben", 64'(bus.writeBackEn), 64'd0);
      check("nw1_pendValid", 64'(bus.pendingValid), 64'd0);
      check("nw1_memReady", 64'(bus.memReady), 64'd1);
      bus.memRdEn = 1'b0;
      step();
      drive_idle();
      check("nw2_wben", 64'(bus.writeBackEn), 64'd0);
      check("nw_retired", 64'(bus.retiredCount), 64'd1);

      // R15 write accepted in the same cycle as a stray response
      bus.ldRespValid = 1'b1;
      bus.ldRespData  = 32'h5555_AAAA;
      alu(4'd15, 32'hF0F0_F0F0);
      drive_idle();
      check("r15_loadErr", 64'(bus.loadErr), 64'd1);
      check("r15_dest", 64'(bus.destWB), 64'd15);
      step();
      check("r15_hold_data", 64'(bus.resultWB), 64'hF0F0_F0F0);
      check("r15_retired", 64'(bus.retiredCount), 64'd2);

      step();
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Hard bound on simulation time
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
